// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-port round-robin arbiter and access sequencer for the
// 16 x 8 register file. Each granted access runs SETUP -> STROBE -> DONE, so
// the address and data lines settle one cycle before the write strobe.
module regfile_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    input  logic [DW-1:0] rf_data_read,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] rf_address,
    output logic [DW-1:0] rf_data_write,
    output logic          rf_write_en
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0] state;
    logic       last;   // 1 = port B was granted most recently
    logic       op;     // 1 = current access is a write
    logic       win_b;

    // Winner selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        win_b = req_b & (~req_a | ~last);
    end

    assign busy = (state != S_IDLE);

    // Sequencer state, grant/done flags and register-file pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            last          <= 1'b1;
            op            <= 1'b0;
            gnt_a         <= 1'b0;
            gnt_b         <= 1'b0;
            done_a        <= 1'b0;
            done_b        <= 1'b0;
            rdata         <= '0;
            rf_address    <= '0;
            rf_data_write <= '0;
            rf_write_en   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_a || req_b) begin
                        state         <= S_SETUP;
                        gnt_a         <= ~win_b;
                        gnt_b         <= win_b;
                        last          <= win_b;
                        op            <= win_b ? we_b : we_a;
                        rf_address    <= win_b ? addr_b : addr_a;
                        rf_data_write <= win_b ? wdata_b : wdata_a;
                    end
                end
                S_SETUP: begin
                    state       <= S_STROBE;
                    rf_write_en <= op;
                end
                S_STROBE: begin
                    state       <= S_DONE;
                    rf_write_en <= 1'b0;
                    done_a      <= gnt_a;
                    done_b      <= gnt_b;
                    if (!op) begin
                        rdata <= rf_data_read;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                    gnt_a  <= 1'b0;
                    gnt_b  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed vector table, hand-written corner sequences and
// randomized two-master traffic checked against a transaction-level model.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic       we_a = 1'b0, we_b = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic [7:0] rf_data_read;
    logic       gnt_a, gnt_b, done_a, done_b, busy, rf_write_en;
    logic [7:0] rdata, rf_data_write;
    logic [3:0] rf_address;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] rf_mem [16];   // environment: the register file itself
    logic [7:0] ref_mem [16];  // model: expected contents in transaction order
    bit         model_last;    // 1 = B served most recently

    regfile_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .rf_data_read(rf_data_read),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .busy(busy),
        .rf_address(rf_address), .rf_data_write(rf_data_write), .rf_write_en(rf_write_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: combinational read, write on rising edge.
    always @(posedge clk) if (rf_write_en) rf_mem[rf_address] <= rf_data_write;
    assign rf_data_read = rf_mem[rf_address];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Mutual exclusion holds on every cycle.
    always @(negedge clk) begin
        chk("one_gnt", 32'(gnt_a & gnt_b), 0);
        chk("one_done", 32'(done_a & done_b), 0);
    end

    task automatic set_port(input bit p, input bit r, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (!p) begin req_a = r; we_a = we; addr_a = a; wdata_a = d; end
        else    begin req_b = r; we_b = we; addr_b = a; wdata_b = d; end
    endtask

    task automatic drop(input bit p);
        if (!p) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_gnt", {gnt_a, gnt_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_addr", 32'(rf_address), 0);
        chk("rst_wdata", 32'(rf_data_write), 0);
        chk("rst_we", 32'(rf_write_en), 0);
        reset = 1'b0;
        model_last = 1'b1;
    endtask

    // One isolated access from IDLE, checked cycle by cycle; ends at an IDLE negedge.
    task automatic access(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input bit scramble);
        logic [7:0] prev;
        prev = rdata;
        set_port(p, 1'b1, we, a, d);
        @(negedge clk);
        chk("c1_gnt", p ? gnt_b : gnt_a, 1);
        chk("c1_other_gnt", p ? gnt_a : gnt_b, 0);
        chk("c1_busy", 32'(busy), 1);
        chk("c1_addr", 32'(rf_address), 32'(a));
        chk("c1_wdata", 32'(rf_data_write), 32'(d));
        chk("c1_we", 32'(rf_write_en), 0);
        if (scramble) set_port(p, 1'b1, we, a ^ 4'hA, d ^ 8'hC3);
        @(negedge clk);
        chk("c2_we", 32'(rf_write_en), 32'(we));
        chk("c2_addr", 32'(rf_address), 32'(a));
        chk("c2_done", {done_a, done_b}, 0);
        @(negedge clk);
        chk("c3_done", p ? done_b : done_a, 1);
        chk("c3_other_gnt", p ? gnt_a : gnt_b, 0);
        chk("c3_we", 32'(rf_write_en), 0);
        chk("c3_rdata", 32'(rdata), we ? 32'(prev) : 32'(exp));
        drop(p);
        if (we) ref_mem[a] = d;
        model_last = p;
        @(negedge clk);
        chk("c4_busy", 32'(busy), 0);
        chk("c4_gnt", {gnt_a, gnt_b}, 0);
        chk("c4_done", {done_a, done_b}, 0);
    endtask

    // Wait for the next done pulse, bounded; optionally scrambles a granted port's inputs.
    task automatic wait_done(input bit scramble, output bit p, output int n);
        p = 1'b0;
        for (n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done_a || done_b) begin
                p = done_b;
                return;
            end
            if (scramble) begin
                if (gnt_a) begin we_a = 1'($urandom); addr_a = 4'($urandom); wdata_a = 8'($urandom); end
                if (gnt_b) begin we_b = 1'($urandom); addr_b = 4'($urandom); wdata_b = 8'($urandom); end
            end
        end
        total++;
        bad++;
        $display("FAIL done_timeout: no done within 12 cycles (t=%0t)", $time);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit         p;
        int         n;
        int         t0;
        bit         exp_p;
        bit         pa, pb;
        bit         wa, wb;
        logic [3:0] aa, ab;
        logic [7:0] da, db;

        for (int i = 0; i < 16; i++) begin
            rf_mem[i]  = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end

        vecs[0] = '{1'b0, 1'b1, 4'd5,  8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 4'd5,  8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b0, 4'd5,  8'h12, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 4'd0,  8'h5A, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h5A};
        vecs[5] = '{1'b1, 1'b1, 4'd15, 8'hFF, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 4'd15, 8'h34, 8'hFF};

        @(negedge clk);
        do_reset();
        @(negedge clk);

        // Directed single accesses.
        for (int i = 0; i < 7; i++)
            access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0);

        // Simultaneous requests straight out of reset: A wins, B follows with no gap.
        do_reset();
        set_port(1'b0, 1'b1, 1'b1, 4'd2, 8'h11);
        set_port(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
        wait_done(1'b0, p, n);
        chk("sim_first_port", 32'(p), 0);
        chk("sim_first_lat", n, 3);
        drop(1'b0);
        ref_mem[2] = 8'h11;
        wait_done(1'b0, p, n);
        chk("sim_second_port", 32'(p), 1);
        chk("sim_second_lat", n, 4);
        chk("sim_rdata", 32'(rdata), 32'h11);
        drop(1'b1);
        model_last = 1'b1;
        @(negedge clk);

        // Round-robin fairness with both masters continuously requesting reads.
        set_port(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
        set_port(1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
        t0 = -1;
        for (int k = 0; k < 8; k++) begin
            exp_p = ~model_last;
            wait_done(1'b0, p, n);
            chk("rr_port", 32'(p), 32'(exp_p));
            chk("rr_rdata", 32'(rdata), 32'(ref_mem[exp_p ? 4'd0 : 4'd5]));
            if (t0 >= 0) chk("rr_spacing", cyc - t0, 4);
            t0 = cyc;
            model_last = exp_p;
            drop(exp_p);
            @(negedge clk);
            if (k < 6) set_port(exp_p, 1'b1, 1'b0, exp_p ? 4'd0 : 4'd5, 8'h00);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (5) @(negedge clk);

        // Winner's inputs changing during SETUP are ignored.
        access(1'b0, 1'b1, 4'd3, 8'h3C, 8'h00, 1'b1);
        access(1'b1, 1'b0, 4'd3, 8'h00, 8'h3C, 1'b0);
        access(1'b0, 1'b0, 4'd9, 8'h00, ref_mem[9], 1'b0);

        // Reset during STROBE of a B write.
        set_port(1'b1, 1'b1, 1'b1, 4'd7, 8'h77);
        @(negedge clk);
        @(negedge clk);
        chk("mid_strobe_we", 32'(rf_write_en), 1);
        drop(1'b1);
        do_reset();
        ref_mem[7] = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_done_b", 32'(done_b), 0);
        end
        set_port(1'b0, 1'b1, 1'b0, 4'd4, 8'h00);
        set_port(1'b1, 1'b1, 1'b0, 4'd7, 8'h00);
        wait_done(1'b0, p, n);
        chk("post_rst_port", 32'(p), 0);
        chk("post_rst_rdata_a", 32'(rdata), 32'(ref_mem[4]));
        drop(1'b0);
        wait_done(1'b0, p, n);
        chk("post_rst_port2", 32'(p), 1);
        chk("post_rst_rdata_b", 32'(rdata), 32'h77);
        drop(1'b1);
        model_last = 1'b1;
        @(negedge clk);

        // Randomized traffic against the transaction-level model.
        for (int r = 0; r < 60; r++) begin
            pa = 1'($urandom); pb = 1'($urandom);
            if (!pa && !pb) pa = 1'b1;
            wa = 1'($urandom); wb = 1'($urandom);
            aa = 4'($urandom); ab = 4'($urandom);
            da = 8'($urandom); db = 8'($urandom);
            set_port(1'b0, pa, wa, aa, da);
            set_port(1'b1, pb, wb, ab, db);
            exp_p = (pa && pb) ? ~model_last : pb;
            for (int s = 0; s < 2; s++) begin
                if (s == 1 && !(pa && pb)) break;
                wait_done(1'b1, p, n);
                chk("rnd_port", 32'(p), 32'(exp_p));
                chk("rnd_lat", n, s == 0 ? 3 : 4);
                if (exp_p) begin
                    if (!wb) chk("rnd_rdata_b", 32'(rdata), 32'(ref_mem[ab]));
                    else ref_mem[ab] = db;
                end else begin
                    if (!wa) chk("rnd_rdata_a", 32'(rdata), 32'(ref_mem[aa]));
                    else ref_mem[aa] = da;
                end
                drop(exp_p);
                model_last = exp_p;
                exp_p = ~exp_p;
            end
            @(negedge clk);
        end

        // The register file contents must match the model after all traffic.
        for (int i = 0; i < 16; i++) chk("final_mem", 32'(rf_mem[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and access sequencer for the 16 x 8 register file. It takes read and write requests from two independent masters (port A, port B), grants one at a time with round-robin priority, and drives the register file's address, write-data and write-enable lines. It also captures read data from the register file's combinational read port. It sits between the FDE datapath masters and the single register file instance, so the register file itself needs no changes.

## Interface
- AW, 4: register file address width (16 entries)
- DW, 8: register file data width

- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_a / req_b  in  1  access request; held high until matching done pulse is sampled
- we_a / we_b  in  1  1 = write, 0 = read; sampled at grant
- addr_a / addr_b  in  AW  target entry; sampled at grant
- wdata_a / wdata_b  in  DW  write data; sampled at grant
- gnt_a / gnt_b  out  1  high while that port owns the register file (SETUP..DONE)
- done_a / done_b  out  1  one-cycle completion pulse, in DONE state only
- rdata  out  DW  read result, shared by both ports; valid while done_x is high after a read
- busy  out  1  high in any state other than IDLE
- rf_address  out  AW  to register file address
- rf_data_write  out  DW  to register file write data
- rf_write_en  out  1  to register file write enable; the register file writes on its rising edge

## Operation
- FSM states: IDLE -> SETUP -> STROBE -> DONE -> IDLE. Every transition is unconditional except IDLE.
- IDLE: if neither req is high, stay. Otherwise choose a winner:
  - If only one port requests, that port wins.
  - If both request, the port that is not `last` wins.
- At the IDLE->SETUP edge, for the winner:
  - latch addr into rf_address and wdata into rf_data_write;
  - latch we into an internal op bit;
  - set gnt_x and set `last` to the winner.
- SETUP: address and data are stable on the register file pins; rf_write_en stays 0.
- STROBE: rf_write_en = op (high for writes only). It is registered, so it rises at the SETUP->STROBE edge, one full cycle after address and data.
- DONE:
  - rf_write_en = 0.
  - For reads, rdata is loaded from rf_data_read at the STROBE->DONE edge.
  - done_x = 1 for exactly this cycle; gnt_x clears at the DONE->IDLE edge.
- Writes leave rdata unchanged.
- Inputs of either port are ignored from SETUP through DONE, including the winner's addr, we and wdata changing, and the loser's req.
- If the winner drops req mid-transaction, the access still completes and done still pulses.
- The requester must drop req at the edge that ends its done cycle. If req stays high, IDLE treats it as a new request.
- rf_address and rf_data_write hold their last values in IDLE; they are not cleared after an access.

## Timing
- Reset, checked at every edge and taking priority over everything else:
  - state = IDLE, `last` = B (so A wins the first tie);
  - rf_address = 0, rf_data_write = 0, rf_write_en = 0;
  - gnt_a = gnt_b = 0, done_a = done_b = 0, rdata = 0, busy = 0.
- Reset mid-operation: all outputs reach their reset values at the next edge, no done is issued, and the transaction is abandoned. If reset lands during STROBE of a write, the register file may already have written (write_en rose); this is accepted.
- Latency: with req sampled high in IDLE at cycle 0, the sequence is SETUP in cycle 1, STROBE in cycle 2, DONE in cycle 3 (done_x high), and IDLE again in cycle 4.
- Throughput: one access per 4 cycles. A waiting loser is granted in cycle 4 with no idle gap, so alternating back-to-back accesses sustain 4 cycles each.
- busy is high in cycles 1-3.
- Only one of gnt_a/gnt_b and one of done_a/done_b is ever high.
- rf_write_en is high for exactly one cycle per write and never high for a read.

## Test plan
- Reset then single write: A writes addr 5 = 0xA5. Required:
  - rf_address = 5 and rf_data_write = 0xA5 in cycle 1;
  - rf_write_en high only in cycle 2;
  - done_a in cycle 3; gnt_b never high.
- Single read: B reads addr 5 after the prior write. Required: done_b in cycle 3 with rdata = 0xA5, and rf_write_en stays 0 throughout.
- Simultaneous requests from reset: A writes addr 2 = 0x11, B reads addr 2, both req raised in the same cycle. Required:
  - A is granted first and done_a lands in cycle 3;
  - B is granted at cycle 4 and done_b lands in cycle 7 with rdata = 0x11.
- Round-robin fairness: A and B both hold req continuously and drop/reassert around each done for 8 accesses. Required: grants alternate A, B, A, B, and each access takes exactly 4 cycles.
- Input stability: A starts a write of addr 3 = 0x3C, then changes addr_a to 9 and wdata_a to 0xFF during SETUP. Required: the register file writes entry 3 = 0x3C, and a later read of entry 9 returns its prior contents.
- Reset mid-operation: assert reset during STROBE of a B write. Required:
  - at the next edge, state is IDLE and all outputs are 0;
  - done_b never pulses;
  - the next simultaneous request is won by A.
